// File: rtl/sisc_pkg.sv
// Shared definitions for the instruction-memory loader.
// Contents:
//   state_t          - loader FSM state encoding (3 bits)
//   LOADER_HDR_BYTES - bytes of word-count header preceding the image
//   WORD_BYTES       - bytes per instruction word (big-endian)
package sisc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam int unsigned LOADER_HDR_BYTES = 2;
  localparam int unsigned WORD_BYTES       = 4;

endpackage

// File: rtl/im_loader_asm.sv
// Byte-to-word assembler for the program loader.
// Shifts bytes in MSB-first and counts them; word_ready strobes (combinationally)
// in the cycle the last byte of a word is being shifted in.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   clear       - zero the byte counter
//   shift_en    - shift in_data into the word this cycle
//   in_data     - byte to shift
//   word        - assembled word (most recent byte in [7:0])
//   word_ready  - shift_en on the final byte of a word
module im_loader_asm
  import sisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0] byte_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (shift_en) begin
      word     <= {word[23:0], in_data};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  assign word_ready = shift_en && (byte_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/im_loader.sv
// Program loader: receives a byte stream (16-bit big-endian word count, then
// count x 4 data bytes MSB first), writes the words to instruction memory from
// address 0 and holds the processor in reset until a complete image is loaded.
// Optional: define IM_LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte (XOR of all count and data bytes) before the image is accepted.
// Ports:
//   clk, rst_f              - clock, asynchronous active-high reset
//   start                   - pulse to begin a load (ignored while busy)
//   in_data/in_valid/in_ready - byte stream handshake
//   im_addr/im_wdata/im_we  - instruction memory write port
//   cpu_hold                - 1 keeps the processor in reset
//   busy/done/error         - load status
//   words_loaded            - words written in the current load
module im_loader
  import sisc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              im_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);

  state_t state, state_next;
  logic        xfer;
  logic [15:0] count_q;
  logic [15:0] len_full;
  logic        last_word;
  logic        clear_asm;
  logic [31:0] asm_word;
  logic        word_ready;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
  localparam state_t FIN_STATE = CHECK;
`else
  localparam state_t FIN_STATE = DONE;
`endif

  assign xfer      = in_valid && in_ready;
  assign len_full  = {count_q[15:8], in_data};
  assign last_word = (32'(words_loaded) + 32'd1) == 32'(count_q);
  assign clear_asm = (state == LEN_LO) && xfer;

  im_loader_asm u_asm (
    .clk        (clk),
    .rst        (rst_f),
    .clear      (clear_asm),
    .shift_en   ((state == DATA) && xfer),
    .in_data    (in_data),
    .word       (asm_word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = LEN_HI;
      LEN_HI: if (xfer) state_next = LEN_LO;
      LEN_LO: if (xfer) begin
        if (32'(len_full) > MAX_WORDS) state_next = ERR;
        else if (len_full == 16'd0)    state_next = FIN_STATE;
        else                           state_next = DATA;
      end
      DATA:   if (word_ready) state_next = WRITE;
      WRITE:  state_next = last_word ? FIN_STATE : DATA;
`ifdef IM_LOADER_CHECKSUM_EN
      CHECK:  if (xfer) state_next = (in_data == csum) ? DONE : ERR;
`endif
      DONE, ERR: if (start) state_next = LEN_HI;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    im_we    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state)
      LEN_HI, LEN_LO, DATA, CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        im_we = 1'b1;
        busy  = 1'b1;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERR:     error = 1'b1;
      default: ;
    endcase
  end

  assign im_addr  = words_loaded;
  assign im_wdata = asm_word;

  // Header capture, write address counter and running checksum.
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      count_q      <= '0;
      words_loaded <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      case (state)
        LEN_HI: if (xfer) count_q[15:8] <= in_data;
        LEN_LO: if (xfer) begin
          count_q[7:0] <= in_data;
          words_loaded <= '0;
        end
        WRITE:  words_loaded <= words_loaded + ADDR_W'(1);
        default: ;
      endcase
`ifdef IM_LOADER_CHECKSUM_EN
      if (start && (state == IDLE || state == DONE || state == ERR))
        csum <= '0;
      else if (xfer && (state == LEN_HI || state == LEN_LO || state == DATA))
        csum <= csum ^ in_data;
`endif
    end
  end

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;

  localparam int unsigned MAXW = 1024;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] im_addr;
  logic [31:0] im_wdata;
  logic        im_we;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int total = 0;
  int bad   = 0;

  wr_t         exp_q[$];
  logic [7:0]  stream[$];
  logic [31:0] words_in[$];

  im_loader #(.ADDR_W(16), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .rst_f        (rst_f),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .im_we        (im_we),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every memory write must match the next expected write.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", 32'(im_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(im_addr), 32'(e.addr));
        chk("wr_data", im_wdata, e.data);
      end
    end
  end

  // Reference model: build byte stream and expected writes from word list.
  task automatic prepare(input int unsigned count, input bit corrupt);
    logic [15:0] c16;
    logic [31:0] w;
    logic [7:0]  x;
    c16 = count[15:0];
    stream.delete();
    stream.push_back(c16[15:8]);
    stream.push_back(c16[7:0]);
    if (count <= MAXW) begin
      for (int unsigned i = 0; i < count; i++) begin
        w = (words_in.size() > 0) ? words_in[i] : $urandom;
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
        exp_q.push_back('{addr: 16'(i), data: w});
      end
`ifdef IM_LOADER_CHECKSUM_EN
      x = 8'h00;
      foreach (stream[k]) x = x ^ stream[k];
      stream.push_back(corrupt ? (x ^ 8'hFF) : x);
`else
      x = 8'h00;
      if (corrupt) x = 8'h00;
`endif
    end
  endtask

  task automatic send(input bit hold);
    int wc;
    int gap;
    foreach (stream[i]) begin
      if (!hold) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          @(negedge clk);
        end
      end
      in_data  = stream[i];
      in_valid = 1'b1;
      wc = 0;
      while (in_ready !== 1'b1 && wc < 50) begin
        @(negedge clk);
        wc++;
      end
      if (wc >= 50) begin
        chk("handshake_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("hold_after_start", 32'(cpu_hold), 32'd1);
  endtask

  task automatic run_load(input int unsigned count, input bit hold, input bit corrupt);
    bit ok;
    int wc;
`ifdef IM_LOADER_CHECKSUM_EN
    ok = (count <= MAXW) && !corrupt;
`else
    ok = (count <= MAXW);
`endif
    prepare(count, corrupt);
    pulse_start();
    send(hold);
    wc = 0;
    while (done !== 1'b1 && error !== 1'b1 && wc < 20) begin
      @(negedge clk);
      wc++;
    end
    chk("done", 32'(done), 32'(ok));
    chk("error", 32'(error), 32'(!ok));
    chk("cpu_hold", 32'(cpu_hold), 32'(!ok));
    chk("busy_end", 32'(busy), 32'd0);
    if (ok) chk("words_loaded", 32'(words_loaded), count);
    repeat (2) @(negedge clk);
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    words_in.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_f    = 1'b1;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_im_addr", 32'(im_addr), 32'd0);
    chk("rst_im_wdata", im_wdata, 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    rst_f = 1'b0;
    @(negedge clk);

    // IDLE ignores stream bytes without a start.
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // Directed two-word image, with gaps and then valid held high.
    words_in = '{32'h1122_3344, 32'hAABB_CCDD};
    run_load(2, 1'b0, 1'b0);
    words_in = '{32'h1122_3344, 32'hAABB_CCDD};
    run_load(2, 1'b1, 1'b0);

    // Oversized count, then zero count.
    run_load(32'h0401, 1'b0, 1'b0);
    run_load(0, 1'b0, 1'b0);
    run_load(MAXW + 1, 1'b1, 1'b0);

    // Reset after two data bytes of a load.
    pulse_start();
    stream.delete();
    stream = '{8'h00, 8'h02, 8'h11, 8'h22};
    send(1'b0);
    #2 rst_f = 1'b1;
    #1;
    chk("midrst_im_we", 32'(im_we), 32'd0);
    chk("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_f = 1'b0;
    @(negedge clk);
    words_in = '{32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1234_5678};
    run_load(3, 1'b0, 1'b0);

`ifdef IM_LOADER_CHECKSUM_EN
    words_in = '{32'h1234_5678};
    run_load(1, 1'b0, 1'b0);
    words_in = '{32'h1234_5678};
    run_load(1, 1'b0, 1'b1);
    run_load(0, 1'b1, 1'b1);
`endif

    // Randomized loads.
    for (int n = 0; n < 8; n++) begin
      run_load($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
